// File: rtl/pc_seq.sv
// Program-counter sequencer: phase-driven fetch increment, trap/eret handling and an optional
// circular return-address stack enabled by the PC_SEQ_RAS_EN macro.
module pc_seq #(
  parameter int          N         = 32,
  parameter int          STEP      = 4,
  parameter logic [N-1:0] RESET_VEC = {N{1'b0}},
  parameter logic [N-1:0] TRAP_VEC  = N'(32'h80),
  parameter int          RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   phase,
  input  logic         stall,
  input  logic         ct_taken,
  input  logic [N-1:0] dr,
  input  logic         trap,
  input  logic         eret,
  input  logic         is_call,
  input  logic         is_ret,
  output logic [N-1:0] pc,
  output logic [N-1:0] epc,
  output logic [N-1:0] ras_top,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         phase_err
);

  localparam logic [N-1:0] STEP_C = N'(STEP);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [N-1:0] pc_r;
  logic [N-1:0] epc_r;
  logic [N-1:0] pc_nxt_s;
  logic [N-1:0] epc_nxt_s;
  logic         phase_err_r;
  logic         onehot_s;
  logic         f_s;
  logic         w_s;
  logic         ras_empty_s;
  logic [N-1:0] ras_top_s;
  logic         ras_push_s;
  logic         ras_pop_s;
  logic         ras_repl_s;

  assign onehot_s = (phase != 5'b00000) && ((phase & (phase - 5'b00001)) == 5'b00000);
  assign f_s      = onehot_s & ~stall & phase[0];
  assign w_s      = onehot_s & ~stall & phase[4];

  // Next pc/epc and RAS operation decode; trap beats eret beats control transfer
  always_comb begin
    pc_nxt_s   = pc_r;
    epc_nxt_s  = epc_r;
    ras_push_s = 1'b0;
    ras_pop_s  = 1'b0;
    ras_repl_s = 1'b0;
    if (f_s) begin
      pc_nxt_s = pc_r + STEP_C;
    end else if (w_s) begin
      if (trap) begin
        pc_nxt_s  = TRAP_VEC;
        epc_nxt_s = pc_r - STEP_C;
      end else if (eret) begin
        pc_nxt_s = epc_r;
      end else if (ct_taken) begin
        if (is_ret && !ras_empty_s) begin
          pc_nxt_s = ras_top_s;
        end else begin
          pc_nxt_s = dr;
        end
        // Call+return on a non-empty stack swaps the top in place
        if (is_call && is_ret) begin
          if (ras_empty_s) begin
            ras_push_s = 1'b1;
          end else begin
            ras_repl_s = 1'b1;
          end
        end else if (is_call) begin
          ras_push_s = 1'b1;
        end else if (is_ret && !ras_empty_s) begin
          ras_pop_s = 1'b1;
        end else begin
          ras_pop_s = 1'b0;
        end
      end else begin
        pc_nxt_s = pc_r;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // PC, EPC and phase error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_VEC;
      epc_r       <= {N{1'b0}};
      phase_err_r <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      epc_r       <= epc_nxt_s;
      phase_err_r <= ~onehot_s;
    end
  end

`ifdef PC_SEQ_RAS_EN
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [N-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PW-1:0] sp_r;
  logic [PW-1:0] sp_inc_s;
  logic [PW:0]   cnt_r;

  assign sp_inc_s    = sp_r + {{(PW-1){1'b0}}, 1'b1};
  assign ras_empty_s = (cnt_r == {(PW+1){1'b0}});
  assign ras_top_s   = ras_empty_s ? {N{1'b0}} : ras_mem_r[sp_r];
  assign ras_full    = (cnt_r == DEPTH_C);

  // Circular stack: a push when full lands on the oldest slot and keeps the count saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r  <= {PW{1'b0}};
      cnt_r <= {(PW+1){1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {N{1'b0}};
      end
    end else if (ras_push_s) begin
      sp_r                <= sp_inc_s;
      ras_mem_r[sp_inc_s] <= pc_r;
      if (cnt_r != DEPTH_C) begin
        cnt_r <= cnt_r + {{PW{1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (ras_pop_s) begin
      sp_r  <= sp_r - {{(PW-1){1'b0}}, 1'b1};
      cnt_r <= cnt_r - {{PW{1'b0}}, 1'b1};
    end else if (ras_repl_s) begin
      ras_mem_r[sp_r] <= pc_r;
    end else begin
      sp_r  <= sp_r;
      cnt_r <= cnt_r;
    end
  end
`else
  logic unused_ras_s;

  assign ras_empty_s  = 1'b1;
  assign ras_top_s    = {N{1'b0}};
  assign ras_full     = 1'b0;
  assign unused_ras_s = ^{ras_push_s, ras_pop_s, ras_repl_s};
`endif

  assign pc        = pc_r;
  assign epc       = epc_r;
  assign ras_top   = ras_top_s;
  assign ras_empty = ras_empty_s;
  assign phase_err = phase_err_r;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue-based reference model predicts every cycle's outputs,
// an independent monitor pops and compares after each rising edge.
module tb_pc_seq;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam logic [4:0] PF = 5'b00001;
  localparam logic [4:0] PW = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  phase = 5'b00000;
  logic        stall = 1'b0;
  logic        ct_taken = 1'b0;
  logic [31:0] dr = 32'h0;
  logic        trap = 1'b0;
  logic        eret = 1'b0;
  logic        is_call = 1'b0;
  logic        is_ret = 1'b0;
  logic [31:0] pc, epc, ras_top;
  logic        ras_empty, ras_full, phase_err;

  pc_seq #(.N(32), .STEP(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h80), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .phase(phase), .stall(stall), .ct_taken(ct_taken), .dr(dr),
    .trap(trap), .eret(eret), .is_call(is_call), .is_ret(is_ret), .pc(pc), .epc(epc),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] top;
    logic        empty;
    logic        full;
    logic        perr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic [31:0] m_ras[$];
  logic        m_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, queue the expected outputs
  task automatic cyc(input logic r, input logic [4:0] ph, input logic st, input logic ct,
                     input logic [31:0] d, input logic tr, input logic er,
                     input logic ca, input logic re);
    logic [31:0] top;
    exp_t        e;
    @(negedge clk);
    rst = r; phase = ph; stall = st; ct_taken = ct; dr = d;
    trap = tr; eret = er; is_call = ca; is_ret = re;
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_perr = 1'b0;
      m_ras.delete();
    end else begin
      m_perr = ($countones(ph) != 1);
      if (!m_perr && !st) begin
        if (ph[0]) begin
          m_pc = m_pc + 32'd4;
        end else if (ph[4]) begin
          if (tr) begin
            m_epc = m_pc - 32'd4;
            m_pc  = 32'h80;
          end else if (er) begin
            m_pc = m_epc;
          end else if (ct) begin
            if (!RAS_ON) begin
              m_pc = d;
            end else if (ca && re) begin
              if (m_ras.size() == 0) begin
                m_ras.push_back(m_pc);
                m_pc = d;
              end else begin
                top = m_ras.pop_back();
                m_ras.push_back(m_pc);
                m_pc = top;
              end
            end else if (re) begin
              if (m_ras.size() > 0) m_pc = m_ras.pop_back();
              else m_pc = d;
            end else if (ca) begin
              if (m_ras.size() == DEPTH) m_ras.delete(0);
              m_ras.push_back(m_pc);
              m_pc = d;
            end else begin
              m_pc = d;
            end
          end
        end
      end
    end
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.top   = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.perr  = m_perr;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued prediction after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("epc", epc, e.epc);
        chk("ras_top", ras_top, e.top);
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        chk("ras_full", {31'b0, ras_full}, {31'b0, e.full});
        chk("phase_err", {31'b0, phase_err}, {31'b0, e.perr});
      end
    end
  end

  initial begin
    logic [4:0]  ph;
    logic [31:0] d;
    // reset, then sequential fetch and wrap at the top of the address space
    cyc(1'b1, PF, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, PW, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    // stall freezes a taken branch, retry applies it
    cyc(0, PW, 0, 1, 32'h100, 0, 0, 0, 0);
    cyc(0, PW, 1, 1, 32'h200, 0, 0, 0, 0);
    cyc(0, PW, 0, 1, 32'h200, 0, 0, 0, 0);
    // trap wins over a taken branch, eret returns to the faulting address
    cyc(0, PW, 0, 1, 32'h104, 0, 0, 0, 0);
    cyc(0, PW, 0, 1, 32'h500, 1, 0, 0, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, PW, 0, 1, 32'h600, 0, 1, 0, 0);
    // five calls overflow a depth-4 stack, then six returns
    cyc(0, PW, 0, 1, 32'h10, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) cyc(0, PW, 0, 1, 32'(i * 16), 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, PW, 0, 1, 32'h990 + 32'(i * 4), 0, 0, 0, 1);
    // call+return on empty then non-empty stack, and ignored hints without ct_taken
    cyc(0, PW, 0, 1, 32'h300, 0, 0, 1, 1);
    cyc(0, PW, 0, 1, 32'h400, 0, 0, 1, 1);
    cyc(0, PW, 0, 0, 32'h500, 0, 0, 1, 1);
    cyc(0, PW, 0, 1, 32'h700, 0, 0, 0, 1);
    // illegal phases
    cyc(0, 5'b00011, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, 5'b00000, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    // reset during a taken call with two entries held
    cyc(0, PW, 0, 1, 32'h1000, 0, 0, 1, 0);
    cyc(0, PW, 0, 1, 32'h2000, 0, 0, 1, 0);
    cyc(1, PW, 0, 1, 32'h3000, 0, 0, 1, 0);
    cyc(0, PF, 0, 0, 32'h0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) ph = 5'($urandom);
      else ph = 5'b00001 << $urandom_range(0, 4);
      d = $urandom & 32'hFFFFFFFC;
      cyc(($urandom_range(0, 99) == 0), ph, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 1) == 1), d, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end
    @(posedge clk);
    #3;
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
